byte_pair_arbiter: RTL and testbench
====================================

Name: byte_pair_arbiter

Overview:
Shares one 8-to-16-bit packing datapath between two byte requesters. A round-robin arbiter grants one requester, locks the grant for two consecutive bytes, and packs them as {first, second} into a 16-bit word. The word is presented on a valid/ready output. A timeout pads an incomplete pair, and a 4-bit bidirectional debug port exposes internal state. The block sits upstream of the 16-bit word consumer.

Parameters:
DATA_W, 8, requester byte width; output word is 2*DATA_W.
TIMEOUT, 15, cycles to wait in LOW for the second byte before padding; legal range 1..255.

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
req0_valid  input  1  requester 0 byte valid
req0_data  input  DATA_W  requester 0 byte
req0_ready  output  1  requester 0 byte accepted when valid&ready
req1_valid  input  1  requester 1 byte valid
req1_data  input  DATA_W  requester 1 byte
req1_ready  output  1  requester 1 byte accepted when valid&ready
out_data  output  2*DATA_W  packed word {high byte, low byte}
out_valid  output  1  word valid
out_ready  input  1  consumer accepts word
out_src  output  1  requester that produced out_data
out_pad  output  1  low byte is padding after timeout
dbg_en  input  1  drive bidir when 1
bidir  inout  4  {state[1:0], grant, out_pad} when dbg_en=1, else high-Z

Behaviour:
- Reset (synchronous, takes effect at the clk edge while reset=1):
  - state=ARB, grant=0, last_served=1, timer=0.
  - out_data=0, out_valid=0, out_src=0, out_pad=0.
  - reqN_ready=0 and bidir=Z while reset is high.
  - A captured high byte is discarded and an undelivered word is dropped.
- State encoding: ARB=2'b00, LOW=2'b01, OUT=2'b10. 2'b11 is unreachable; if entered, return to ARB next cycle.
- ARB:
  - Winner = the single valid requester. If both are valid, winner = the requester not equal to last_served.
  - reqN_ready is combinational: 1 only for the winner, 0 if neither is valid.
  - On transfer: capture the byte as high byte, grant=winner, timer=0, go to LOW.
- LOW:
  - Ready is asserted only for the granted requester. The other requester's ready=0 regardless of its valid.
  - On transfer: out_data={high, byte}, out_src=grant, out_pad=0, out_valid=1, go to OUT.
  - With no transfer, timer increments each cycle. When timer reaches TIMEOUT-1 without a transfer:
    - next edge sets out_data={high, 8'h00}, out_pad=1, out_valid=1, and goes to OUT.
    - A transfer on that same cycle wins over the timeout (no padding).
- OUT:
  - Both readys are 0.
  - out_data, out_src and out_pad hold stable while out_valid=1 && !out_ready.
  - On out_ready: out_valid=0, last_served=out_src, go to ARB.
  - No bypass: the earliest next acceptance is the cycle after the handshake.
- Latency and throughput:
  - First byte to out_valid: 2 cycles minimum (ARB accept, LOW accept, word registered).
  - Maximum throughput is one word per 3 cycles.
- bidir:
  - Drives the registered debug value combinationally gated by dbg_en.
  - The block never samples bidir.
- Arithmetic: the timer is 8 bits and cannot wrap, because it is cleared on entry to LOW and leaves LOW at TIMEOUT-1.

Test Plan:
- Reset, then req0 sends 0xA5 then 0x3C; out_ready=1 -> out_data=0xA53C, out_src=0, out_pad=0, out_valid high exactly 1 cycle.
- req0 and req1 both valid continuously, out_ready=1 -> words alternate src 0,1,0,1, starting with req0; req1 is never granted while req0 holds the lock mid-pair.
- req1 sends 0x77 then drops valid for TIMEOUT=15 cycles -> out_data=0x7700, out_pad=1, src=1; a later req1 byte starts a new pair.
- Word 0x1234 completes with out_ready=0 for 5 cycles -> out_data is held stable, both readys stay 0, and the next grant happens only after the handshake.
- Assert reset while in LOW holding high byte 0xEE -> next cycle all outputs are 0, state=ARB, and no 0xEExx word is ever emitted.
- dbg_en toggled 0/1 during LOW with grant=1 -> bidir = Z / 4'b0110.

Source files
------------

// File: rtl/byte_pair_arbiter_if.sv
// Byte-requester and packed-word handshake bundle for byte_pair_arbiter.
// Latency: none, wires only.
// Backpressure: req*_ready and out_ready carry the flow control.
interface byte_pair_arbiter_if #(
    parameter int DATA_W = 8
);
    logic                  req0_valid;
    logic [DATA_W-1:0]     req0_data;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [DATA_W-1:0]     req1_data;
    logic                  req1_ready;
    logic [2*DATA_W-1:0]   out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_src;
    logic                  out_pad;

    // Requesters and word consumer side.
    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, out_ready,
        input  req0_ready, req1_ready, out_data, out_valid, out_src, out_pad
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
        output req0_ready, req1_ready, out_data, out_valid, out_src, out_pad
    );
endinterface

// File: rtl/byte_pair_arbiter.sv
// Round-robin arbiter packing two bytes from one requester into a 16-bit word.
// Latency: 2 cycles from first byte accept to out_valid; one word per 3 cycles max.
// Backpressure: readys drop while a word waits; word held until out_ready.
module byte_pair_arbiter #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    byte_pair_arbiter_if.slave   bus,
    input  logic                 dbg_en,
    inout  wire  [3:0]           bidir
);
    typedef enum logic [1:0] {
        ARB = 2'b00,
        LOW = 2'b01,
        OUT = 2'b10
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t              state;
    state_t              state_next;
    logic                grant;
    logic                last_served;
    logic [7:0]          timer;
    logic [DATA_W-1:0]   high;
    logic [2*DATA_W-1:0] out_data_r;
    logic                out_valid_r;
    logic                out_src_r;
    logic                out_pad_r;

    logic                any_valid;
    logic                winner;
    logic                rdy0;
    logic                rdy1;
    logic                arb_xfer;
    logic                low_xfer;
    logic [DATA_W-1:0]   low_byte;
    logic                timed_out;
    logic [3:0]          dbg;

    // Arbitration and per-requester ready; both readys are forced low in reset.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        winner    = (bus.req0_valid && bus.req1_valid) ? ~last_served : bus.req1_valid;
        rdy0      = 1'b0;
        rdy1      = 1'b0;
        if (!reset) begin
            case (state)
                ARB: begin
                    rdy0 = any_valid && !winner;
                    rdy1 = any_valid && winner;
                end
                LOW: begin
                    rdy0 = !grant;
                    rdy1 = grant;
                end
                default: ;
            endcase
        end
        arb_xfer  = (rdy0 && bus.req0_valid) || (rdy1 && bus.req1_valid);
        low_xfer  = grant ? (rdy1 && bus.req1_valid) : (rdy0 && bus.req0_valid);
        low_byte  = grant ? bus.req1_data : bus.req0_data;
        timed_out = (timer == TIMER_LAST);
    end

    // Next-state: accept high byte, wait for low byte or timeout, wait for consumer.
    always_comb begin
        state_next = state;
        case (state)
            ARB:     if (arb_xfer) state_next = LOW;
            LOW:     if (low_xfer || timed_out) state_next = OUT;
            OUT:     if (bus.out_ready) state_next = ARB;
            default: state_next = ARB;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ARB;
        else       state <= state_next;
    end

    // Datapath: capture high byte, pack or pad the word, hold it until accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant       <= 1'b0;
            last_served <= 1'b1;
            timer       <= 8'd0;
            high        <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            out_src_r   <= 1'b0;
            out_pad_r   <= 1'b0;
        end else begin
            case (state)
                ARB: if (arb_xfer) begin
                    high  <= winner ? bus.req1_data : bus.req0_data;
                    grant <= winner;
                    timer <= 8'd0;
                end
                LOW: begin
                    // A byte arriving on the timeout cycle still completes the pair.
                    if (low_xfer) begin
                        out_data_r  <= {high, low_byte};
                        out_src_r   <= grant;
                        out_pad_r   <= 1'b0;
                        out_valid_r <= 1'b1;
                    end else if (timed_out) begin
                        out_data_r  <= {high, {DATA_W{1'b0}}};
                        out_src_r   <= grant;
                        out_pad_r   <= 1'b1;
                        out_valid_r <= 1'b1;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                OUT: if (bus.out_ready) begin
                    out_valid_r <= 1'b0;
                    last_served <= out_src_r;
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.out_data   = out_data_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_src    = out_src_r;
    assign bus.out_pad    = out_pad_r;

    // Debug port only ever drives; released while reset is high.
    assign dbg   = {state, grant, out_pad_r};
    assign bidir = (dbg_en && !reset) ? dbg : 4'bzzzz;
endmodule

// File: tb/tb_byte_pair_arbiter.sv
// Scoreboard bench for byte_pair_arbiter: directed scenarios then random traffic.
// Latency: reference model advances once per cycle at the falling edge.
// Backpressure: out_ready is driven randomly to exercise word holding.
module tb_byte_pair_arbiter;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic dbg_en = 1'b0;
    wire  [3:0] bidir;

    // A released debug port reads back as all ones.
    pullup (bidir[0]);
    pullup (bidir[1]);
    pullup (bidir[2]);
    pullup (bidir[3]);

    byte_pair_arbiter_if #(.DATA_W(DATA_W)) bus ();

    byte_pair_arbiter #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .dbg_en (dbg_en),
        .bidir  (bidir)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] data;
        logic        src;
        logic        pad;
    } word_t;
    word_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pair is either not started, half collected, or waiting
    // for the consumer; the model decides who may send and what word results.
    int         pair_owner = -1;   // requester whose pair is half collected
    logic [7:0] pair_high;
    int         idle_cycles;
    bit         word_waiting = 0;
    bit         waiting_src;
    int         last_src = 1;
    bit         grant_m = 0;
    bit         pad_m = 0;
    int         win;
    bit         e0, e1;
    logic [1:0] phase;
    word_t      w;

    always @(negedge clk) begin
        if (reset) begin
            check("rdy0_in_reset", bus.req0_ready, 0);
            check("rdy1_in_reset", bus.req1_ready, 0);
            check("bidir_in_reset", bidir, 4'hF);
            pair_owner   = -1;
            word_waiting = 0;
            last_src     = 1;
            grant_m      = 0;
            pad_m        = 0;
            idle_cycles  = 0;
            exp_q.delete();
        end else begin
            win = -1;
            e0  = 0;
            e1  = 0;
            if (!word_waiting) begin
                if (pair_owner < 0) begin
                    if (bus.req0_valid && bus.req1_valid) win = 1 - last_src;
                    else if (bus.req0_valid)              win = 0;
                    else if (bus.req1_valid)              win = 1;
                    e0 = (win == 0);
                    e1 = (win == 1);
                end else begin
                    e0 = (pair_owner == 0);
                    e1 = (pair_owner == 1);
                end
            end
            check("req0_ready", bus.req0_ready, e0);
            check("req1_ready", bus.req1_ready, e1);
            check("out_valid", bus.out_valid, word_waiting);
            phase = word_waiting ? 2'd2 : (pair_owner >= 0 ? 2'd1 : 2'd0);
            if (dbg_en) check("bidir_driven", bidir, {phase, grant_m, pad_m});
            else        check("bidir_released", bidir, 4'hF);

            if (word_waiting) begin
                if (bus.out_ready) begin
                    word_waiting = 0;
                    last_src     = waiting_src;
                end
            end else if (pair_owner < 0) begin
                if (win >= 0) begin
                    pair_owner  = win;
                    grant_m     = win[0];
                    pair_high   = (win == 1) ? bus.req1_data : bus.req0_data;
                    idle_cycles = 0;
                end
            end else begin
                if (pair_owner == 1 ? bus.req1_valid : bus.req0_valid) begin
                    w.data = {pair_high, (pair_owner == 1) ? bus.req1_data : bus.req0_data};
                    w.pad  = 0;
                end else begin
                    idle_cycles++;
                    w.pad = (idle_cycles == TIMEOUT);
                    w.data = {pair_high, 8'h00};
                end
                if ((pair_owner == 1 ? bus.req1_valid : bus.req0_valid) || w.pad) begin
                    w.src        = grant_m;
                    pad_m        = w.pad;
                    waiting_src  = grant_m;
                    word_waiting = 1;
                    pair_owner   = -1;
                    exp_q.push_back(w);
                end
            end
        end
    end

    // Monitor: every presented word must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h src %0d pad %0d expected none",
                         bus.out_data, bus.out_src, bus.out_pad);
            end else begin
                check("out_data", bus.out_data, exp_q[0].data);
                check("out_src", bus.out_src, exp_q[0].src);
                check("out_pad", bus.out_pad, exp_q[0].pad);
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 0;
        bus.req1_valid = 0;
    endtask

    task automatic pulse_reset();
        reset = 1;
        cyc(2);
        reset = 0;
    endtask

    initial begin
        bus.req0_valid = 0;
        bus.req0_data  = 0;
        bus.req1_valid = 0;
        bus.req1_data  = 0;
        bus.out_ready  = 0;
        cyc(2);
        check("reset_out_data", bus.out_data, 0);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out_src", bus.out_src, 0);
        check("reset_out_pad", bus.out_pad, 0);
        reset = 0;

        // Single pair from requester 0.
        bus.out_ready = 1;
        bus.req0_valid = 1; bus.req0_data = 8'hA5;
        cyc(1);
        bus.req0_data = 8'h3C;
        cyc(1);
        idle_inputs();
        check("pair_a53c_data", bus.out_data, 16'hA53C);
        check("pair_a53c_src", bus.out_src, 0);
        check("pair_a53c_valid", bus.out_valid, 1);
        cyc(3);

        // Both requesters always valid: pairs alternate starting with requester 0.
        pulse_reset();
        bus.req0_valid = 1;
        bus.req1_valid = 1;
        for (int i = 0; i < 24; i++) begin
            bus.req0_data = 8'($urandom);
            bus.req1_data = 8'($urandom);
            cyc(1);
        end
        idle_inputs();
        cyc(4);

        // Requester 1 leaves its pair half finished: padded word after timeout.
        bus.req1_valid = 1; bus.req1_data = 8'h77;
        cyc(1);
        bus.req1_valid = 0;
        cyc(TIMEOUT);
        check("pad_data", bus.out_data, 16'h7700);
        check("pad_flag", bus.out_pad, 1);
        check("pad_src", bus.out_src, 1);
        cyc(1);
        bus.req1_valid = 1; bus.req1_data = 8'h11;
        cyc(1);
        bus.req1_data = 8'h22;
        cyc(1);
        idle_inputs();
        cyc(3);

        // Consumer stalls for 5 cycles while both requesters keep offering.
        bus.out_ready = 0;
        bus.req0_valid = 1; bus.req0_data = 8'h12;
        cyc(1);
        bus.req0_data = 8'h34;
        cyc(1);
        bus.req1_valid = 1; bus.req1_data = 8'h99; bus.req0_data = 8'h56;
        cyc(5);
        check("stall_hold_data", bus.out_data, 16'h1234);
        bus.out_ready = 1;
        cyc(4);
        idle_inputs();
        cyc(4);

        // Reset while a high byte is held: that byte is never emitted.
        bus.req0_valid = 1; bus.req0_data = 8'hEE;
        cyc(1);
        idle_inputs();
        cyc(2);
        reset = 1;
        cyc(1);
        check("rst_mid_out_valid", bus.out_valid, 0);
        check("rst_mid_out_data", bus.out_data, 0);
        check("rst_mid_rdy0", bus.req0_ready, 0);
        reset = 0;
        dbg_en = 1;
        #1;
        check("rst_mid_dbg_arb", bidir, 4'b0000);
        dbg_en = 0;

        // Debug port toggled while requester 1 holds a half pair.
        bus.req1_valid = 1; bus.req1_data = 8'h55;
        cyc(1);
        bus.req1_valid = 0;
        #1;
        check("dbg_off_z", bidir, 4'hF);
        dbg_en = 1;
        #1;
        check("dbg_on_low_g1", bidir, 4'b0110);
        dbg_en = 0;
        bus.req1_valid = 1; bus.req1_data = 8'h66;
        cyc(1);
        idle_inputs();
        cyc(3);

        // Random traffic with random backpressure, debug enables and rare resets.
        for (int i = 0; i < 3000; i++) begin
            bus.req0_valid = ($urandom_range(0, 3) != 0);
            bus.req1_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) bus.req0_valid = 0;
            bus.req0_data  = 8'($urandom);
            bus.req1_data  = 8'($urandom);
            bus.out_ready  = ($urandom_range(0, 9) < 7);
            dbg_en         = $urandom_range(0, 1) != 0;
            reset          = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 19) == 0) idle_inputs();
            cyc(1);
        end
        reset = 0;

        // Drain any outstanding pair or word.
        idle_inputs();
        bus.out_ready = 1;
        cyc(TIMEOUT + 6);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
